// File: rtl/register_file_if.sv
// Commit, issue and operand-read bus between the ROB/issue logic and the register file.
interface register_file_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 need_write_to_regfile;
  logic [4:0]           reg_id;
  logic [31:0]          data;
  logic [ROB_WIDTH-1:0] commit_rob_id;

  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [ROB_WIDTH-1:0] issue_rob_id;

  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;

  modport master (
    output need_write_to_regfile, reg_id, data, commit_rob_id,
    output issue_valid, issue_rd, issue_rob_id,
    output rs1_id, rs2_id,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  need_write_to_regfile, reg_id, data, commit_rob_id,
    input  issue_valid, issue_rd, issue_rob_id,
    input  rs1_id, rs2_id,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with ROB rename-tag tracking and two combinational read ports.
// Define REGFILE_COMMIT_BYPASS_EN to forward a matching commit value to the read ports in the commit cycle.
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_pipline,
  register_file_if.slave  rf
);

  logic [31:0]          regs [0:31];
  logic                 busy [0:31];
  logic [ROB_WIDTH-1:0] tag  [0:31];

  logic commit_en;
  logic commit_clears_busy;
  logic issue_en;

  assign commit_en          = rf.need_write_to_regfile && (rf.reg_id != 5'd0);
  assign commit_clears_busy = commit_en && busy[rf.reg_id] && (tag[rf.reg_id] == rf.commit_rob_id);
  assign issue_en           = rf.issue_valid && (rf.issue_rd != 5'd0) && !flush_pipline;

  // Issue is applied after the commit clear so a same-register issue wins busy/tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        busy[i] <= 1'b0;
        tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        regs[rf.reg_id] <= rf.data;
      end
      if (commit_clears_busy) begin
        busy[rf.reg_id] <= 1'b0;
      end
      if (flush_pipline) begin
        for (int i = 0; i < 32; i++) begin
          busy[i] <= 1'b0;
          tag[i]  <= '0;
        end
      end else if (issue_en) begin
        busy[rf.issue_rd] <= 1'b1;
        tag[rf.issue_rd]  <= rf.issue_rob_id;
      end
    end
  end

`ifdef REGFILE_COMMIT_BYPASS_EN
  logic rs1_bypass;
  logic rs2_bypass;

  assign rs1_bypass = rdy_in && commit_en && (rf.reg_id == rf.rs1_id) &&
                      busy[rf.rs1_id] && (tag[rf.rs1_id] == rf.commit_rob_id);
  assign rs2_bypass = rdy_in && commit_en && (rf.reg_id == rf.rs2_id) &&
                      busy[rf.rs2_id] && (tag[rf.rs2_id] == rf.commit_rob_id);
`endif

  always_comb begin
    rf.rs1_value = '0;
    rf.rs1_busy  = 1'b0;
    rf.rs1_tag   = '0;
    if (rf.rs1_id != 5'd0) begin
      rf.rs1_value = regs[rf.rs1_id];
      rf.rs1_busy  = busy[rf.rs1_id];
      rf.rs1_tag   = tag[rf.rs1_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (rs1_bypass) begin
        rf.rs1_value = rf.data;
        rf.rs1_busy  = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rf.rs2_value = '0;
    rf.rs2_busy  = 1'b0;
    rf.rs2_tag   = '0;
    if (rf.rs2_id != 5'd0) begin
      rf.rs2_value = regs[rf.rs2_id];
      rf.rs2_busy  = busy[rf.rs2_id];
      rf.rs2_tag   = tag[rf.rs2_id];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (rs2_bypass) begin
        rf.rs2_value = rf.data;
        rf.rs2_busy  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against a reference model.
module tb_register_file;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;

  register_file_if #(.ROB_WIDTH(RW)) bus ();

  register_file #(.ROB_WIDTH(RW)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .flush_pipline (flush),
    .rf            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_regs [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drives all inputs on the falling edge so they are stable around the next rising edge.
  task automatic applyStimulus(input logic r, input logic rd, input logic fl,
                               input logic cv, input logic [4:0] cid, input logic [31:0] cdata,
                               input logic [RW-1:0] crob, input logic iv, input logic [4:0] ird,
                               input logic [RW-1:0] irob, input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    rst   = r;
    rdy   = rd;
    flush = fl;
    bus.need_write_to_regfile = cv;
    bus.reg_id        = cid;
    bus.data          = cdata;
    bus.commit_rob_id = crob;
    bus.issue_valid   = iv;
    bus.issue_rd      = ird;
    bus.issue_rob_id  = irob;
    bus.rs1_id        = s1;
    bus.rs2_id        = s2;
    #1;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b0, 5'd0, '0, s1, s2);
  endtask

  task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output logic b,
                            output logic [RW-1:0] t, output logic byp);
    v = 32'h0; b = 1'b0; t = '0; byp = 1'b0;
    if (rs != 5'd0) begin
      v = m_regs[rs]; b = m_busy[rs]; t = m_tag[rs];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (rdy && bus.need_write_to_regfile && bus.reg_id == rs && m_busy[rs] &&
          m_tag[rs] == bus.commit_rob_id) begin
        v = bus.data; b = 1'b0; byp = 1'b1;
      end
`endif
    end
  endtask

  // Compares both read ports against the model for the inputs currently applied.
  task automatic checkOutput(input string name);
    logic [31:0] v; logic b; logic [RW-1:0] t; logic byp;
    model_read(bus.rs1_id, v, b, t, byp);
    check_eq({name, ".rs1_value"}, bus.rs1_value, v);
    check_eq({name, ".rs1_busy"}, {31'h0, bus.rs1_busy}, {31'h0, b});
    if (!byp) check_eq({name, ".rs1_tag"}, {28'h0, bus.rs1_tag}, {28'h0, t});
    model_read(bus.rs2_id, v, b, t, byp);
    check_eq({name, ".rs2_value"}, bus.rs2_value, v);
    check_eq({name, ".rs2_busy"}, {31'h0, bus.rs2_busy}, {31'h0, b});
    if (!byp) check_eq({name, ".rs2_tag"}, {28'h0, bus.rs2_tag}, {28'h0, t});
  endtask

  // Rising edge: advance the reference model using the inputs held across the edge.
  task automatic clock_edge();
    int  rd;
    bit  hit;
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) begin m_regs[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else if (rdy) begin
      rd  = int'(bus.reg_id);
      hit = bus.need_write_to_regfile && rd != 0 && m_busy[rd] && m_tag[rd] == bus.commit_rob_id;
      if (bus.need_write_to_regfile && rd != 0) m_regs[rd] = bus.data;
      if (hit) m_busy[rd] = 1'b0;
      if (flush) begin
        foreach (m_busy[i]) begin m_busy[i] = 0; m_tag[i] = 0; end
      end else if (bus.issue_valid && bus.issue_rd != 5'd0) begin
        m_busy[bus.issue_rd] = 1'b1;
        m_tag[bus.issue_rd]  = bus.issue_rob_id;
      end
    end
  endtask

  task automatic commit_issue(input logic cv, input logic [4:0] cid, input logic [31:0] cdata,
                              input logic [RW-1:0] crob, input logic iv, input logic [4:0] ird,
                              input logic [RW-1:0] irob);
    applyStimulus(1'b0, 1'b1, 1'b0, cv, cid, cdata, crob, iv, ird, irob, 5'd0, 5'd0);
    clock_edge();
  endtask

  initial begin
    // Reset and x0 behaviour
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    clock_edge();
    clock_edge();
    idle(5'd5, 5'd0);
    checkOutput("reset");
    check_eq("reset.x5_value", bus.rs1_value, 32'h0);
    check_eq("reset.x5_busy", {31'h0, bus.rs1_busy}, 32'h0);
    check_eq("reset.x0_value", bus.rs2_value, 32'h0);
    clock_edge();
    commit_issue(1'b1, 5'd0, 32'hDEADBEEF, 4'd0, 1'b0, 5'd0, 4'd0);
    idle(5'd0, 5'd0);
    check_eq("x0.value", bus.rs1_value, 32'h0);
    clock_edge();

    // Issue then matching commit
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd3, 4'd2);
    idle(5'd3, 5'd0);
    check_eq("x3.busy", {31'h0, bus.rs1_busy}, 32'h1);
    check_eq("x3.tag", {28'h0, bus.rs1_tag}, 32'h2);
    clock_edge();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1234, 4'd2, 1'b0, 5'd0, '0, 5'd3, 5'd3);
    checkOutput("x3.commit_cycle");
`ifdef REGFILE_COMMIT_BYPASS_EN
    check_eq("x3.bypass_value", bus.rs1_value, 32'h1234);
    check_eq("x3.bypass_busy", {31'h0, bus.rs1_busy}, 32'h0);
`else
    check_eq("x3.nobypass_busy", {31'h0, bus.rs1_busy}, 32'h1);
`endif
    clock_edge();
    idle(5'd3, 5'd0);
    check_eq("x3.after_value", bus.rs1_value, 32'h1234);
    check_eq("x3.after_busy", {31'h0, bus.rs1_busy}, 32'h0);
    clock_edge();

    // Stale commit after rename
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd4, 4'd1);
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd4, 4'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'd7, 4'd1, 1'b0, 5'd0, '0, 5'd4, 5'd0);
    checkOutput("x4.stale_cycle");
    clock_edge();
    idle(5'd4, 5'd0);
    check_eq("x4.stale_value", bus.rs1_value, 32'd7);
    check_eq("x4.stale_busy", {31'h0, bus.rs1_busy}, 32'h1);
    check_eq("x4.stale_tag", {28'h0, bus.rs1_tag}, 32'h5);
    clock_edge();
    commit_issue(1'b1, 5'd4, 32'd9, 4'd5, 1'b0, 5'd0, 4'd0);
    idle(5'd4, 5'd0);
    check_eq("x4.final_value", bus.rs1_value, 32'd9);
    check_eq("x4.final_busy", {31'h0, bus.rs1_busy}, 32'h0);
    clock_edge();

    // Same-cycle commit and issue to one register
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd6, 4'd3);
    commit_issue(1'b1, 5'd6, 32'hAA, 4'd3, 1'b1, 5'd6, 4'd6);
    idle(5'd6, 5'd0);
    check_eq("x6.value", bus.rs1_value, 32'hAA);
    check_eq("x6.busy", {31'h0, bus.rs1_busy}, 32'h1);
    check_eq("x6.tag", {28'h0, bus.rs1_tag}, 32'h6);
    clock_edge();

    // Flush with simultaneous commit and issue
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd1, 4'd1);
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd2, 4'd2);
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd7, 4'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h55, 4'd2, 1'b1, 5'd8, 4'd8, 5'd1, 5'd7);
    clock_edge();
    idle(5'd2, 5'd8);
    checkOutput("flush.x2_x8");
    check_eq("flush.x2_value", bus.rs1_value, 32'h55);
    check_eq("flush.x2_busy", {31'h0, bus.rs1_busy}, 32'h0);
    check_eq("flush.x2_tag", {28'h0, bus.rs1_tag}, 32'h0);
    check_eq("flush.x8_busy", {31'h0, bus.rs2_busy}, 32'h0);
    clock_edge();
    idle(5'd1, 5'd7);
    check_eq("flush.x1_busy", {31'h0, bus.rs1_busy}, 32'h0);
    check_eq("flush.x7_busy", {31'h0, bus.rs2_busy}, 32'h0);
    clock_edge();

    // rdy_in low freezes state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 4'd0, 1'b1, 5'd10, 4'd3, 5'd9, 5'd10);
    clock_edge();
    idle(5'd9, 5'd10);
    check_eq("stall.x9_value", bus.rs1_value, 32'h0);
    check_eq("stall.x10_busy", {31'h0, bus.rs2_busy}, 32'h0);
    clock_edge();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h77, 4'd0, 1'b1, 5'd10, 4'd3, 5'd9, 5'd10);
    clock_edge();
    idle(5'd9, 5'd10);
    check_eq("ready.x9_value", bus.rs1_value, 32'h77);
    check_eq("ready.x10_busy", {31'h0, bus.rs2_busy}, 32'h1);
    check_eq("ready.x10_tag", {28'h0, bus.rs2_tag}, 32'h3);
    clock_edge();

    // Randomized traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] cid, ird, s1, s2;
      logic [RW-1:0] crob, irob;
      cid  = 5'($urandom_range(0, 7));
      ird  = 5'($urandom_range(0, 7));
      crob = ($urandom_range(0, 1) == 0) ? m_tag[cid] : RW'($urandom);
      irob = RW'($urandom);
      s1   = ($urandom_range(0, 2) == 0) ? cid : 5'($urandom_range(0, 7));
      s2   = ($urandom_range(0, 2) == 0) ? cid : 5'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 24) == 0), 1'($urandom), cid, $urandom, crob,
                    1'($urandom), ird, irob, s1, s2);
      checkOutput("random");
      clock_edge();
    end

    // Reset while stalled with pending commit and issue
    commit_issue(1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd10, 4'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 4'd0, 1'b1, 5'd11, 4'd2, 5'd9, 5'd10);
    clock_edge();
    idle(5'd9, 5'd10);
    checkOutput("midreset");
    check_eq("midreset.x9_value", bus.rs1_value, 32'h0);
    check_eq("midreset.x10_busy", {31'h0, bus.rs2_busy}, 32'h0);
    check_eq("midreset.x10_tag", {28'h0, bus.rs2_tag}, 32'h0);
    clock_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with rename-tag tracking, sitting directly downstream of the reorder buffer. It retires committed results (`need_write_to_regfile`/`reg_id`/`data`) into 32×32-bit registers. For the issue stage, it records which ROB entry will produce each register. It serves two combinational source-operand lookups returning either a ready value or a pending ROB tag.

## Interface
Parameters:
- `ROB_WIDTH`, 4, bit width of a ROB entry index (ROB depth = 2^ROB_WIDTH)

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  synchronous, active-high reset
- `rdy_in`  in  1  CPU ready; low freezes all state updates
- `flush_pipline`  in  1  misprediction flush; clears all pending tags
- `need_write_to_regfile`  in  1  ROB commit valid
- `reg_id`  in  5  commit destination register
- `data`  in  32  commit value
- `commit_rob_id`  in  ROB_WIDTH  ROB index of committing entry
- `issue_valid`  in  1  new instruction issued with destination register
- `issue_rd`  in  5  issued destination register
- `issue_rob_id`  in  ROB_WIDTH  ROB index allocated to issued instruction
- `rs1_id`, `rs2_id`  in  5 each  source register indices
- `rs1_value`, `rs2_value`  out  32 each  register value (valid when not busy)
- `rs1_busy`, `rs2_busy`  out  1 each  value pending in ROB
- `rs1_tag`, `rs2_tag`  out  ROB_WIDTH each  producing ROB index when busy

## Operation
- State: `regs[0:31]` (32 b), `busy[0:31]` (1 b), `tag[0:31]` (ROB_WIDTH b). x0 is never written, never busy, and always reads 0 with tag 0.
- All updates occur on the rising `clk_in` edge, only when `rst_in`=0 and `rdy_in`=1.
- Commit (`need_write_to_regfile`=1, `reg_id`≠0):
  - `regs[reg_id]` <= `data`, unconditionally.
  - `busy[reg_id]` is cleared only if `busy`=1 and `tag[reg_id]`==`commit_rob_id`. A stale commit whose register has since been renamed leaves busy/tag untouched.
- Issue (`issue_valid`=1, `issue_rd`≠0, no flush): `busy[issue_rd]`<=1, `tag[issue_rd]`<=`issue_rob_id`.
- Same cycle, commit and issue to the same register: value is written, and issue wins busy/tag (busy=1, new tag).
- Flush: all `busy` cleared and tags zeroed. A same-cycle commit still writes its value. A same-cycle issue is ignored.
- Read port n (combinational):
  - rs=0 → value 0, busy 0, tag 0.
  - Bypass hit (see Configuration) → value=`data`, busy 0.
  - Otherwise → value=`regs[rs]`, busy=`busy[rs]`, tag=`tag[rs]`.
- Same-cycle issue does not affect read outputs. The issue stage handles intra-bundle dependency itself.

## Timing
- Reads: 0-cycle combinational from state and commit inputs.
- Writes and tag changes: visible at read ports the cycle after the qualifying edge.
- Reset (sync): all regs=0, busy=0, tag=0. With rs ids at 0, all outputs read 0.
- Reset mid-operation: state is cleared at that edge regardless of `rdy_in`, commit, or issue.
- `rdy_in`=0: no state change. Reads remain live. Commit/issue presented that cycle are dropped (upstream holds them).
- No handshake back-pressure: the block always accepts commit and issue in one cycle.

## Configuration
- `REGFILE_COMMIT_BYPASS_EN` defined:
  - A read port bypasses when `rdy_in`=1, `need_write_to_regfile`=1, `reg_id`==rs≠0, `busy[rs]`=1 and `tag[rs]`==`commit_rob_id`.
  - On bypass it returns `data` with busy=0 in the same cycle as the commit.
- Undefined: no bypass. Read outputs reflect registered state only, so a committed value appears one cycle later.

## Test plan
- Reset, then read x5/x0 → value 0, busy 0, tag 0. Attempt commit to x0 with data 0xDEADBEEF → x0 still reads 0.
- Issue rd=x3 rob 2, next cycle read x3 → busy 1, tag 2. Commit x3 rob 2 data 0x1234 → next cycle busy 0, value 0x1234. With bypass, the commit cycle already shows 0x1234, busy 0.
- Issue x4 rob 1, then issue x4 rob 5, then commit x4 rob 1 data 7 → value 7 but busy 1, tag 5. Commit x4 rob 5 data 9 → busy 0, value 9.
- Same cycle: commit x6 rob 3 data 0xAA (x6 tag 3) and issue x6 rob 6 → next cycle value 0xAA, busy 1, tag 6.
- Issue x1,x2,x7 busy, then flush with a simultaneous commit x2 data 0x55 and issue x8 → all busy 0, x2=0x55, x8 not busy.
- Hold `rdy_in`=0 while presenting commit x9 data 0x77 and issue x10 → no state change. Raise `rdy_in` → updates apply that edge.
